// File: rtl/subleq_control_pkg.sv
// Shared word-size default and FSM state encoding for the SUBLEQ controller.
package subleq_control_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FA   = 3'd1,
    FB   = 3'd2,
    FC   = 3'd3,
    RA   = 3'd4,
    RB   = 3'd5,
    WB   = 3'd6,
    HALT = 3'd7
  } state_t;

endpackage

// File: rtl/subleq_alu.sv
// SUBLEQ arithmetic: res = rb - ra (wrapping), leq flags res <= 0 as two's complement.
module subleq_alu #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic [WORD_SIZE-1:0] ra,
  input  logic [WORD_SIZE-1:0] rb,
  output logic [WORD_SIZE-1:0] res,
  output logic                 leq
);

  assign res = rb - ra;
  assign leq = (res == '0) | res[WORD_SIZE-1];

endmodule

// File: rtl/subleq_control.sv
// SUBLEQ instruction sequencer: fetch A/B/C, read operands, write back, branch.
// Optional macro SUBLEQ_HALT_EN: a taken branch to a target with MSB set halts.
module subleq_control
  import subleq_control_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 run,
  output logic                 load,
  output logic                 store,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] mem_in,
  input  logic [WORD_SIZE-1:0] mem_out,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 instr_done
);

  state_t state, state_next;

  logic [WORD_SIZE-1:0] op_a, op_b, op_c;
  logic [WORD_SIZE-1:0] ra, rb;
  logic [WORD_SIZE-1:0] res;
  logic                 leq;
  logic                 halt_jump;

  subleq_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .ra  (ra),
    .rb  (rb),
    .res (res),
    .leq (leq)
  );

`ifdef SUBLEQ_HALT_EN
  assign halt_jump = leq & op_c[WORD_SIZE-1];
`else
  assign halt_jump = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = FA;
      FA:      state_next = FB;
      FB:      state_next = FC;
      FC:      state_next = RA;
      RA:      state_next = RB;
      RB:      state_next = WB;
      WB: begin
        if (halt_jump)  state_next = HALT;
        else if (run)   state_next = FA;
        else            state_next = IDLE;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= IDLE;
      pc    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      state <= state_next;
      case (state)
        FA: op_a <= mem_out;
        FB: op_b <= mem_out;
        FC: op_c <= mem_out;
        RA: ra   <= mem_out;
        RB: rb   <= mem_out;
        WB: pc   <= leq ? op_c : pc + WORD_SIZE'(3);
        default: ;
      endcase
    end
  end

  // Outputs are gated by areset so a reset landing in WB suppresses that edge's store.
  always_comb begin
    load       = 1'b0;
    store      = 1'b0;
    addr       = '0;
    mem_in     = '0;
    busy       = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;
    if (!areset) begin
      case (state)
        FA: begin
          load = 1'b1;
          addr = pc;
          busy = 1'b1;
        end
        FB: begin
          load = 1'b1;
          addr = pc + WORD_SIZE'(1);
          busy = 1'b1;
        end
        FC: begin
          load = 1'b1;
          addr = pc + WORD_SIZE'(2);
          busy = 1'b1;
        end
        RA: begin
          load = 1'b1;
          addr = op_a;
          busy = 1'b1;
        end
        RB: begin
          load = 1'b1;
          addr = op_b;
          busy = 1'b1;
        end
        WB: begin
          store      = 1'b1;
          addr       = op_b;
          mem_in     = res;
          busy       = 1'b1;
          instr_done = 1'b1;
        end
`ifdef SUBLEQ_HALT_EN
        HALT: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_control.sv
// Bench for subleq_control: instruction-level reference model expanded into an expected bus trace.
module tb_subleq_control;

  logic       clk = 1'b0;
  logic       areset, run;
  logic       load, store, busy, halted, instr_done;
  logic [7:0] addr, mem_in, mem_out, pc;

  subleq_control #(.WORD_SIZE(8)) dut (
    .clk        (clk),
    .areset     (areset),
    .run        (run),
    .load       (load),
    .store      (store),
    .addr       (addr),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

`ifdef SUBLEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_ldst   = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] load_addrs[$];

  assign mem_out = mem[addr];
  always @(posedge clk) if (store) mem[addr] = mem_in;

  typedef struct {
    logic       load;
    logic       store;
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } rec_t;

  rec_t       q[$];
  logic [7:0] m_pc = '0;
  logic       m_halt = 1'b0;
  logic [7:0] m_next_pc;
  logic       m_next_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one whole SUBLEQ instruction per call, turned into six bus cycles.
  always @(posedge clk) begin : model
    rec_t       rec;
    logic [7:0] a, b, c, x, y, r;
    logic       taken;
    if (areset) begin
      q.delete();
      m_pc   = '0;
      m_halt = 1'b0;
    end else begin
      if (q.size() > 0) begin
        rec = q.pop_front();
        if (rec.store) ref_mem[rec.addr] = rec.data;
        if (rec.done) begin
          m_pc   = m_next_pc;
          m_halt = m_next_halt;
        end
      end
      if (q.size() == 0 && run && !m_halt) begin
        a = ref_mem[m_pc];
        b = ref_mem[m_pc + 8'd1];
        c = ref_mem[m_pc + 8'd2];
        x = ref_mem[a];
        y = ref_mem[b];
        r = y - x;
        taken = ($signed(r) <= 0);
        m_next_pc   = taken ? c : m_pc + 8'd3;
        m_next_halt = HALT_EN && taken && c[7];
        q.push_back('{1'b1, 1'b0, m_pc,        8'd0, 1'b0});
        q.push_back('{1'b1, 1'b0, m_pc + 8'd1, 8'd0, 1'b0});
        q.push_back('{1'b1, 1'b0, m_pc + 8'd2, 8'd0, 1'b0});
        q.push_back('{1'b1, 1'b0, a,           8'd0, 1'b0});
        q.push_back('{1'b1, 1'b0, b,           8'd0, 1'b0});
        q.push_back('{1'b0, 1'b1, b,           r,    1'b1});
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [20:0] act, exp;
    act = {load, store, addr, mem_in, busy, halted, instr_done};
    if (areset) begin
      exp = '0;
      check("outputs_in_reset", 32'(act), 32'(exp));
    end else begin
      if (q.size() > 0)
        exp = {q[0].load, q[0].store, q[0].addr, q[0].data, 1'b1, 1'b0, q[0].done};
      else
        exp = {1'b0, 1'b0, 8'd0, 8'd0, 1'b0, m_halt, 1'b0};
      check("bus_cycle", 32'(act), 32'(exp));
      check("pc_cycle", 32'(pc), 32'(m_pc));
    end
    if (instr_done) n_done++;
    if (load || store) n_ldst++;
    if (load) load_addrs.push_back(addr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic do_reset();
    run    = 1'b0;
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] va, input logic [7:0] vb);
    for (int unsigned i = 0; i < 256; i++) poke(8'(i), 8'd0);
    poke(8'd0, a);
    poke(8'd1, b);
    poke(8'd2, c);
    poke(a, va);
    poke(b, vb);
  endtask

  task automatic one_instr();
    n_done = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    run    = 1'b0;
    areset = 1'b1;
    for (int unsigned i = 0; i < 256; i++) poke(8'(i), 8'd0);
    tick();
    tick();
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_outs", 32'({load, store, addr, mem_in, busy, halted, instr_done}), 32'd0);
    areset = 1'b0;

    // 5 - 3 = 2, positive: fall through to pc+3
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    one_instr();
    check("basic_mem11", 32'(mem[11]), 32'd2);
    check("basic_pc", 32'(pc), 32'd3);
    check("basic_done_count", 32'(n_done), 32'd1);

    // zero result branches
    do_reset();
    load_prog(8'd10, 8'd11, 8'd20, 8'd5, 8'd5);
    one_instr();
    check("zero_mem11", 32'(mem[11]), 32'd0);
    check("zero_pc", 32'(pc), 32'd20);

    // A == B clears the word and branches
    do_reset();
    load_prog(8'd10, 8'd10, 8'd9, 8'd7, 8'd7);
    one_instr();
    check("same_mem10", 32'(mem[10]), 32'd0);
    check("same_pc", 32'(pc), 32'd9);

    // reset during WB discards the store
    do_reset();
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 12 && !store; i++) tick();
    check("wb_reached", 32'(store), 32'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("wbreset_mem11", 32'(mem[11]), 32'd5);
    check("wbreset_pc", 32'(pc), 32'd0);
    check("wbreset_outs", 32'({load, store, addr, mem_in, busy, halted, instr_done}), 32'd0);
    n_ldst = 0;
    repeat (4) tick();
    check("wbreset_idle", 32'(n_ldst), 32'd0);

    // run dropped in FB: instruction still completes
    do_reset();
    load_prog(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
    n_done = 0;
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    repeat (8) tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_pc", 32'(pc), 32'd3);
    check("drop_done_count", 32'(n_done), 32'd1);
    check("drop_mem11", 32'(mem[11]), 32'd2);

    // negative branch target 0xFF
    do_reset();
    load_prog(8'd10, 8'd11, 8'hFF, 8'd5, 8'd3);
    load_addrs.delete();
    run = 1'b1;
`ifdef SUBLEQ_HALT_EN
    for (int i = 0; i < 30 && !halted; i++) tick();
    n_ldst = 0;
    repeat (20) tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'hFF);
    check("halt_quiet", 32'(n_ldst), 32'd0);
    check("halt_mem11", 32'(mem[11]), 32'hFE);
`else
    repeat (20) tick();
    run = 1'b0;
    repeat (8) tick();
    check("wrap_trace_len", 32'(load_addrs.size() >= 8), 32'd1);
    if (load_addrs.size() >= 8) begin
      check("wrap_fetch0", 32'(load_addrs[5]), 32'hFF);
      check("wrap_fetch1", 32'(load_addrs[6]), 32'h00);
      check("wrap_fetch2", 32'(load_addrs[7]), 32'h01);
    end
    check("halted_tied_low", 32'(halted), 32'd0);
`endif

    // randomized programs, run toggling and occasional resets
    run    = 1'b0;
    areset = 1'b1;
    for (int unsigned i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    tick();
    areset = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (halted || $urandom_range(0, 299) == 0) begin
        run    = 1'b0;
        areset = 1'b1;
        for (int unsigned i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
      end else begin
        areset = 1'b0;
        run    = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    areset = 1'b0;
    run    = 1'b0;
    repeat (10) tick();
    for (int unsigned i = 0; i < 256; i++)
      check("final_mem", {mem[i], 8'(i)}, {ref_mem[i], 8'(i)});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/subleq_control.md
SUBLEQ_CONTROL -- requirements
Module: subleq_control

Interface
REQ-001 The block SHALL use the parameter `WORD_SIZE` (default 8, from defines.vh) as the width of every data and address signal.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port areset, input, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have port run, input, 1 bit; while high, the block starts new instructions.
REQ-005 The block SHALL have port load, output, 1 bit, the memory read enable.
REQ-006 The block SHALL have port store, output, 1 bit, the memory write enable; the write commits on the clk edge.
REQ-007 The block SHALL have port addr, output, WORD_SIZE bits, the memory address.
REQ-008 The block SHALL have port mem_in, output, WORD_SIZE bits, the memory write data.
REQ-009 The block SHALL have port mem_out, input, WORD_SIZE bits, the combinational memory read data, valid in the same cycle as load/addr.
REQ-010 The block SHALL have port pc, output, WORD_SIZE bits, the address of the current instruction.
REQ-011 The block SHALL have port busy, output, 1 bit, high in every state except IDLE and HALT.
REQ-012 The block SHALL have port halted, output, 1 bit, high in HALT.
REQ-013 The block SHALL have port instr_done, output, 1 bit, a one-cycle pulse on the clock edge that completes WB.

Function
REQ-014 The block SHALL use the states IDLE, FA, FB, FC, RA, RB, WB, HALT, each lasting one cycle.
REQ-015 IDLE SHALL go to FA when run=1 and stay in IDLE otherwise.
REQ-016 The fetch states SHALL drive load=1 and latch mem_out: FA uses addr=pc and latches opA; FB uses addr=pc+1 and latches opB; FC uses addr=pc+2 and latches opC.
REQ-017 The read states SHALL drive load=1 and latch mem_out: RA uses addr=opA and latches ra; RB uses addr=opB and latches rb.
REQ-018 WB SHALL drive store=1, load=0, addr=opB and mem_in=res, where res = rb-ra mod 2^WORD_SIZE.
REQ-019 In WB, branch SHALL be taken when res==0 or res[MSB]==1 (two's-complement res<=0).
REQ-020 On leaving WB, pc SHALL become opC if the branch is taken and pc+3 otherwise, with the addition wrapping mod 2^WORD_SIZE.
REQ-021 WB SHALL go to FA if run=1 and to IDLE otherwise; run=0 mid-instruction completes the instruction, so there are no partial writes.
REQ-022 All instructions SHALL take exactly 6 cycles, from FA through WB.
REQ-023 In every state except WB, store SHALL be 0 and mem_in SHALL be 0; in IDLE and HALT, load, store and addr SHALL all be 0.
REQ-024 If opA==opB, then ra==rb, so res=0, mem[opB] is written 0 and the branch is taken.
REQ-025 Self-modifying code SHALL work: a WB write to pc..pc+2 of the next instruction is seen by the following FA/FB/FC fetches.
REQ-026 pc+1 and pc+2 SHALL wrap, so pc=2^W-1 fetches from addresses 2^W-1, 0 and 1.

Reset
REQ-027 While areset=1 at a clk edge, the block SHALL enter IDLE with pc=0 and opA, opB, opC, ra and rb all 0.
REQ-028 During and after reset, load, store, addr, mem_in, busy, halted and instr_done SHALL all be 0.
REQ-029 A reset mid-instruction, including in WB, SHALL abort the instruction: the WB store is not committed, because reset has priority over the store for that edge.
REQ-030 HALT SHALL be left only by reset.

Configuration
REQ-031 The feature SHALL be controlled by the macro SUBLEQ_HALT_EN.
REQ-032 With SUBLEQ_HALT_EN defined, a taken branch whose opC has its MSB set SHALL go to HALT, with pc=opC and halted=1, instead of FA/IDLE; the store still commits.
REQ-033 Without SUBLEQ_HALT_EN, the HALT state SHALL be unreachable, halted SHALL be tied to 0, and a negative opC is an ordinary jump target.

Structure
REQ-034 defines.vh SHALL hold WORD_SIZE and the state encoding constants (3-bit, 8 states) as shared defines.
REQ-035 A sub-module subleq_alu SHALL be used: combinational, inputs ra and rb, outputs res and leq.
REQ-036 The FSM, operand registers and pc SHALL stay in subleq_control.

Verification
REQ-037 With W=8, mem[0..2]={10,11,6}, mem[10]=3, mem[11]=5 and run=1, the bench SHALL check mem[11]=2 after 6 cycles, pc=3, and instr_done pulsed once.
REQ-038 With mem[10]=5, mem[11]=5 and C=20, the bench SHALL check mem[11]=0 and pc=20 (taken on zero).
REQ-039 With A==B==10 and mem[10]=7, the bench SHALL check mem[10]=0 and the branch taken.
REQ-040 Asserting areset in the WB cycle SHALL leave the target word unchanged, with pc=0, state IDLE and all outputs 0.
REQ-041 Dropping run during FB SHALL let the instruction complete, then the block idles with busy=0 and pc advanced.
REQ-042 With SUBLEQ_HALT_EN, a taken branch to C=0xFF SHALL give halted=1 with no further load/store for 20 cycles; without SUBLEQ_HALT_EN, the same program SHALL fetch from 0xFF, 0x00 and 0x01.
